// File: rtl/div_config_sequencer.sv
// Divider configuration sequencer: accepts a divide ratio, strobes it into the
// divider (LOAD), lets it settle one cycle, then runs the divider on request.
module div_config_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfgValid,
  input  logic [WIDTH-1:0] cfgData,
  output logic             cfgReady,
  input  logic             runReq,
  output logic             enable,
  output logic             configDiv,
  output logic [WIDTH-1:0] din,
  output logic             running,
  output logic             cfgErr
);

  // state  | meaning
  // IDLE   | divider stopped, ratio transfers accepted
  // LOAD   | configDiv high, divider captures din
  // SETTLE | configDiv low, divisor latched, one quiet cycle
  // RUN    | divider enabled, ratio transfers accepted
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  logic [1:0] state, state_nxt;
  logic       loaded, loaded_nxt;
  logic       xfer, reject;

  // cfgReady is a registered copy of (state is IDLE or RUN)
  assign xfer   = cfgValid && cfgReady;
  assign reject = xfer && (cfgData == WIDTH'(1));

  always_comb begin
    state_nxt  = state;
    loaded_nxt = loaded;
    if (reject) begin
      state_nxt = state;
    end else if (xfer) begin
      state_nxt  = ST_LOAD;
      loaded_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE:   if (runReq && loaded) state_nxt = ST_RUN;
        ST_LOAD:   state_nxt = ST_SETTLE;
        ST_SETTLE: state_nxt = (runReq && loaded) ? ST_RUN : ST_IDLE;
        ST_RUN:    if (!runReq) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they are registered yet align with it;
  // enable and configDiv therefore can never be high together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      loaded    <= 1'b0;
      din       <= '0;
      enable    <= 1'b0;
      running   <= 1'b0;
      configDiv <= 1'b0;
      cfgReady  <= 1'b1;
      cfgErr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      loaded    <= loaded_nxt;
      if (xfer && !reject) din <= cfgData;
      enable    <= (state_nxt == ST_RUN);
      running   <= (state_nxt == ST_RUN);
      configDiv <= (state_nxt == ST_LOAD);
      cfgReady  <= (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);
      cfgErr    <= reject;
    end
  end

endmodule

// File: doc/div_config_sequencer.md
DIV_CONFIG_SEQUENCER -- requirements
Module: div_config_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, width of the divide-ratio word.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cfgValid  input  1  new divide ratio offered on cfgData.
REQ-006 cfgData  input  WIDTH  requested divide ratio.
REQ-007 cfgReady  output  1  sequencer can accept a ratio this cycle.
REQ-008 runReq  input  1  level request for the divider to run.
REQ-009 enable  output  1  divider enable.
REQ-010 configDiv  output  1  divider load strobe (1 = capture din, 0 = latch divisor).
REQ-011 din  output  WIDTH  ratio presented to the divider.
REQ-012 running  output  1  copy of enable.
REQ-013 cfgErr  output  1  one-cycle pulse on a rejected ratio.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 FSM states SHALL be IDLE, LOAD, SETTLE and RUN.
REQ-016 cfgReady SHALL be 1 in IDLE and RUN, and 0 in LOAD and SETTLE.
REQ-017 A transfer SHALL occur at any rising edge with cfgValid=1 and cfgReady=1.
REQ-018 Transfer with cfgData==1: reject; cfgErr=1 for exactly one cycle; state, din and loaded flag unchanged.
REQ-019 Transfer with cfgData!=1 (0 allowed, pass-through ratio): din<=cfgData, loaded<=1, next state LOAD.
REQ-020 LOAD: enable=0, configDiv=1, lasting exactly one cycle, then SETTLE.
REQ-021 SETTLE: enable=0, configDiv=0, lasting exactly one cycle; then RUN if runReq=1, else IDLE.
REQ-022 IDLE: enable=0, configDiv=0; go to RUN when runReq=1, loaded=1 and no transfer.
REQ-023 RUN: enable=1, configDiv=0; runReq=0 -> IDLE (enable=0 after the next edge).
REQ-024 Transfer in RUN -> LOAD; enable SHALL drop on the same edge, with no cycle where enable=1 and configDiv=1.
REQ-025 A transfer SHALL take priority over runReq in every state that accepts transfers.
REQ-026 runReq=0 together with a transfer in RUN -> LOAD, SETTLE, IDLE.
REQ-027 runReq SHALL be ignored while loaded=0.
REQ-028 Latency: transfer at edge N -> configDiv=1 after edge N, 0 after N+1; enable=1 after N+2 when runReq=1.
REQ-029 din SHALL change only on an accepted transfer and SHALL hold in all other cycles.
REQ-030 running SHALL equal enable in every cycle.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, enable=0, configDiv=0, din=0, running=0, cfgErr=0, cfgReady=1, loaded=0.
REQ-032 Reset asserted mid-sequence (LOAD/SETTLE/RUN) SHALL abort the sequence with no further output pulses.
REQ-033 After reset deassertion, behaviour SHALL match IDLE with loaded=0; runReq has no effect until a ratio is accepted.

Verification
REQ-034 Reset, runReq=1, no cfg -> enable stays 0 for 20 cycles.
REQ-035 cfgData=10 accepted at edge N, runReq=1 -> configDiv=1 during N..N+1, din=10, enable=1 from N+2, cfgReady=0 for 2 cycles.
REQ-036 In RUN, cfgData=4 offered -> enable=0 after the same edge, LOAD, SETTLE, then RUN with din=4; never enable&configDiv.
REQ-037 cfgData=1 offered in IDLE and in RUN -> cfgErr single-cycle pulse, din and enable unchanged.
REQ-038 runReq dropped in RUN together with cfgData=6 -> LOAD, SETTLE, IDLE; din=6; enable=0.
REQ-039 reset pulsed low during SETTLE -> all outputs at reset values at once; runReq=1 afterwards -> enable stays 0.
